// File: rtl/i2c_target_regs_if.sv
// I2C pad and local register-bus signals of the I2C target.
// slave is the target's view; master is the environment (pads + register bus).
interface i2c_target_regs_if #(
    parameter int REG_AW = 8
);
    logic              scl_read;
    logic              sda_read;
    logic              sda_write;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;

    modport slave (
        input  scl_read, sda_read, reg_rdata,
        output sda_write, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output scl_read, sda_read, reg_rdata,
        input  sda_write, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target bridging an external I2C controller to a byte-wide local register bus.
// Never stretches SCL; SDA is open-drain (0 = pull low, 1 = release).
module i2c_target_regs_filt #(
    parameter int FILTER_LEN = 3
) (
    input  logic CLK,
    input  logic reset_in,
    input  logic i_raw,
    output logic o_filt
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // Idle I2C lines are high, so the filter resets to 1 and produces no event.
    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_filt;
endmodule

module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h42,
    parameter int         FILTER_LEN = 3,
    parameter int         REG_AW     = 8
) (
    input logic              CLK,
    input logic              reset_in,
    i2c_target_regs_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic w_scl_f, w_sda_f;
    logic r_scl_d, r_sda_d;

    i2c_target_regs_filt #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .CLK(CLK), .reset_in(reset_in), .i_raw(bus.scl_read), .o_filt(w_scl_f));
    i2c_target_regs_filt #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .CLK(CLK), .reset_in(reset_in), .i_raw(bus.sda_read), .o_filt(w_sda_f));

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    assign w_start    = r_sda_d & ~w_sda_f & w_scl_f & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda_f & w_scl_f & r_scl_d;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [3:0]        r_bitcnt, w_bitcnt_nxt;
    logic              r_rw, w_rw_nxt;
    logic              r_first, w_first_nxt;
    logic              r_ack_drv, w_ack_drv_nxt;
    logic              r_sda_w, w_sda_w_nxt;
    logic              r_busy, w_busy_nxt;
    logic [REG_AW-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_wdata, w_wdata_nxt;
    logic              r_we, w_we_nxt;
    logic              r_re, w_re_nxt;
    logic              r_re_d;
    logic [7:0]        w_byte;

    assign w_byte = {r_shift[6:0], w_sda_f};

    always_ff @(posedge CLK or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_ack_drv <= 1'b0;
            r_sda_w   <= 1'b1;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_re_d    <= 1'b0;
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_rw      <= w_rw_nxt;
            r_first   <= w_first_nxt;
            r_ack_drv <= w_ack_drv_nxt;
            r_sda_w   <= w_sda_w_nxt;
            r_busy    <= w_busy_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_we      <= w_we_nxt;
            r_re      <= w_re_nxt;
            r_re_d    <= r_re;
            r_scl_d   <= w_scl_f;
            r_sda_d   <= w_sda_f;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_rw_nxt      = r_rw;
        w_first_nxt   = r_first;
        w_ack_drv_nxt = r_ack_drv;
        w_sda_w_nxt   = r_sda_w;
        w_busy_nxt    = r_busy;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_we_nxt      = 1'b0;
        w_re_nxt      = 1'b0;

        // Bus conditions outrank any SCL edge seen in the same cycle.
        if (w_start || w_stop) begin
            w_state_nxt  = w_start ? S_ADDR : S_IDLE;
            w_sda_w_nxt  = 1'b1;
            w_bitcnt_nxt = '0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt  = w_byte;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_bitcnt_nxt  = '0;
                        w_ack_drv_nxt = 1'b0;
                        if (w_byte[7:1] == DEV_ADDR) begin
                            w_state_nxt = S_ADDR_ACK;
                            w_rw_nxt    = w_byte[0];
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                // First fall pulls SDA low; a read leaves on the 9th rise (SDA then
                // carries the MSB from the next fall), a write on the 9th fall.
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_w_nxt   = 1'b0;
                        w_ack_drv_nxt = 1'b1;
                    end else begin
                        w_sda_w_nxt  = 1'b1;
                        w_first_nxt  = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = S_WR_BYTE;
                    end
                end else if (w_scl_rise && r_ack_drv && r_rw) begin
                    w_re_nxt     = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_RD_BYTE;
                end
                S_WR_BYTE: if (w_scl_rise) begin
                    w_shift_nxt  = w_byte;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_bitcnt_nxt  = '0;
                        w_ack_drv_nxt = 1'b0;
                        w_state_nxt   = S_WR_ACK;
                        if (r_first) begin
                            w_addr_nxt = REG_AW'(w_byte);
                        end else begin
                            w_wdata_nxt = w_byte;
                            w_we_nxt    = 1'b1;
                        end
                    end
                end else if (w_scl_fall) begin
                    w_sda_w_nxt = 1'b1;
                end
                S_WR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_w_nxt   = 1'b0;
                        w_ack_drv_nxt = 1'b1;
                    end else begin
                        w_sda_w_nxt = 1'b1;
                        if (!r_first)
                            w_addr_nxt = r_addr + REG_AW'(1);
                        w_first_nxt = 1'b0;
                        w_state_nxt = S_WR_BYTE;
                    end
                end
                S_RD_BYTE: if (w_scl_fall) begin
                    if (r_bitcnt < 4'd8) begin
                        w_sda_w_nxt  = r_shift[7];
                        w_shift_nxt  = {r_shift[6:0], 1'b1};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else begin
                        w_sda_w_nxt = 1'b1;
                        w_state_nxt = S_RD_ACK;
                    end
                end
                S_RD_ACK: if (w_scl_rise) begin
                    if (!w_sda_f) begin
                        w_re_nxt     = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = S_RD_BYTE;
                    end else begin
                        w_state_nxt = S_WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end

        // Read pipeline: pointer advances the cycle after reg_re, data lands one later.
        if (r_re)
            w_addr_nxt = r_addr + REG_AW'(1);
        if (r_re_d)
            w_shift_nxt = bus.reg_rdata;
    end

    assign bus.sda_write = r_sda_w;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C controller plus a
// registered register-bus model returning reg[a] = a ^ 0xFF.
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic [7:0] rdata_q = 8'h00;
    logic line;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0, re_cnt = 0, low_cnt = 0, busy_cnt = 0, both_cnt = 0;
    logic [7:0] we_a [0:15];
    logic [7:0] we_d [0:15];

    i2c_target_regs_if #(.REG_AW(8)) bus ();

    i2c_target_regs #(.DEV_ADDR(7'h42), .FILTER_LEN(3), .REG_AW(8)) dut (
        .CLK(clk), .reset_in(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    assign line          = sda_m & bus.sda_write;
    assign bus.scl_read  = scl_m;
    assign bus.sda_read  = line;
    assign bus.reg_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.reg_re) begin
            rdata_q <= bus.reg_addr ^ 8'hFF;
            re_cnt  <= re_cnt + 1;
        end
        if (bus.reg_we) begin
            we_a[we_cnt[3:0]] <= bus.reg_addr;
            we_d[we_cnt[3:0]] <= bus.reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (!bus.sda_write) low_cnt <= low_cnt + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.reg_we && bus.reg_re) both_cnt <= both_cnt + 1;
    end

    task automatic wq(input int n = Q);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic do_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    // n bits MSB first; optional 2-CLK low glitch during the high phase of the MSB
    task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wq();
            scl_m = 1'b1; wq();
            if (glitch && i == 7) begin
                sda_m = 1'b0; wq(2);
                sda_m = 1'b1;
            end
            wq();
            scl_m = 1'b0; wq();
        end
    endtask

    task automatic get_ack(output logic a);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        a = line; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8, 1'b0);
        get_ack(a);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq();
            scl_m = 1'b1; wq();
            b[i] = line; wq();
            scl_m = 1'b0; wq();
        end
        sda_m = ack; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    initial begin
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1;
        int we0, re0, low0, busy0;

        // Reset values
        wq(5);
        chk("rst_sda_write", bus.sda_write, 1);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_reg_wdata", bus.reg_wdata, 0);
        chk("rst_reg_we", bus.reg_we, 0);
        chk("rst_reg_re", bus.reg_re, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        wq(20);

        // 1: pointer 0x10, write 0xAA, 0x55
        do_start();
        send_byte(8'h84, a0);
        chk("t1_busy_mid", bus.busy, 1);
        send_byte(8'h10, a1);
        send_byte(8'hAA, a2);
        send_byte(8'h55, a3);
        do_stop();
        wq();
        chk("t1_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("t1_we_cnt", we_cnt, 2);
        chk("t1_we0", {we_a[0], we_d[0]}, 16'h10AA);
        chk("t1_we1", {we_a[1], we_d[1]}, 16'h1155);
        chk("t1_addr", bus.reg_addr, 8'h12);
        chk("t1_busy_after_p", bus.busy, 0);

        // 2: pointer 0x20, Sr, read 2 bytes
        re0 = re_cnt;
        do_start();
        send_byte(8'h84, a0);
        send_byte(8'h20, a1);
        do_rstart();
        send_byte(8'h85, a2);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        do_stop();
        wq();
        chk("t2_acks", {a0, a1, a2}, 3'b000);
        chk("t2_rd0", d0, 8'hDF);
        chk("t2_rd1", d1, 8'hDE);
        chk("t2_re_cnt", re_cnt - re0, 2);
        chk("t2_addr", bus.reg_addr, 8'h22);

        // 3: wrong address
        we0 = we_cnt; re0 = re_cnt; low0 = low_cnt; busy0 = busy_cnt;
        do_start();
        send_byte(8'h90, a0);
        send_byte(8'h12, a1);
        do_stop();
        wq();
        chk("t3_nacks", {a0, a1}, 2'b11);
        chk("t3_no_low", low_cnt - low0, 0);
        chk("t3_no_strobe", (we_cnt - we0) + (re_cnt - re0), 0);
        chk("t3_no_busy", busy_cnt - busy0, 0);

        // 4: pointer wrap
        do_start();
        send_byte(8'h84, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h01, a2);
        send_byte(8'h02, a3);
        do_stop();
        wq();
        chk("t4_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("t4_we0", {we_a[2], we_d[2]}, 16'hFF01);
        chk("t4_we1", {we_a[3], we_d[3]}, 16'h0002);
        chk("t4_addr", bus.reg_addr, 8'h01);

        // 5a: 2-CLK SDA glitch with SCL high must not abort the write
        do_start();
        send_byte(8'h84, a0);
        send_byte(8'h30, a1);
        send_bits(8'hC3, 8, 1'b1);
        get_ack(a2);
        chk("t5a_busy", bus.busy, 1);
        do_stop();
        wq();
        chk("t5a_acks", {a0, a1, a2}, 3'b000);
        chk("t5a_we", {we_a[4], we_d[4]}, 16'h30C3);
        chk("t5a_addr", bus.reg_addr, 8'h31);

        // 5b: STOP half-way through a data byte
        do_start();
        send_byte(8'h84, a0);
        send_byte(8'h40, a1);
        we0 = we_cnt;
        send_bits(8'hA5, 4, 1'b0);
        do_stop();
        wq();
        chk("t5b_no_we", we_cnt - we0, 0);
        chk("t5b_busy", bus.busy, 0);
        chk("t5b_sda_rel", bus.sda_write, 1);
        chk("t5b_addr", bus.reg_addr, 8'h40);

        // 6: asynchronous reset while the address ACK is being driven
        do_start();
        send_bits(8'h84, 8, 1'b0);
        chk("t6_pre_ack_low", bus.sda_write, 0);
        chk("t6_pre_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_sda_write", bus.sda_write, 1);
        chk("t6_reg_addr", bus.reg_addr, 0);
        chk("t6_reg_wdata", bus.reg_wdata, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_strobes", {bus.reg_we, bus.reg_re}, 2'b00);
        wq(3);
        sda_m = 1'b1; scl_m = 1'b1;
        rst = 1'b0;
        wq(20);
        chk("t6_idle_sda", bus.sda_write, 1);
        chk("we_re_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
